// File: rtl/ps2_scan_fifo_if.sv
// ps2_scan_fifo_if: byte-strobe / CPU-poll bundle for ps2_scan_fifo.
// master = PS/2 receiver + CPU side, slave = ps2_scan_fifo.
interface ps2_scan_fifo_if #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [7:0]    RX_DATA;
   logic          RX_STB;
   logic          POP;
   logic          CLR_OVF;
   logic [7:0]    O_CODE;
   logic          O_REL;
   logic          O_EXT;
   logic          O_EMPTY;
   logic [CW-1:0] O_COUNT;
   logic          O_OVF;
   logic [7:0]    O_STATUS;
   logic          O_IRQ;

   modport master (
      output RX_DATA, RX_STB, POP, CLR_OVF,
      input  O_CODE, O_REL, O_EXT, O_EMPTY, O_COUNT, O_OVF, O_STATUS, O_IRQ
   );

   modport slave (
      input  RX_DATA, RX_STB, POP, CLR_OVF,
      output O_CODE, O_REL, O_EXT, O_EMPTY, O_COUNT, O_OVF, O_STATUS, O_IRQ
   );
endinterface

// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo: folds AT set-2 E0/F0 prefixes into key events and queues
// them in a first-word-fall-through FIFO with sticky overflow and toggle IRQ.
// Optional: define SCAN_TYPEMATIC_FILTER_EN to drop typematic repeats of the
// currently held make code.
module ps2_scan_fifo #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 50000
) (
   input logic            CLOCK,
   input logic            RESET_N,
   ps2_scan_fifo_if.slave bus
);
   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned TW      = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
   localparam logic [AW:0] FULLCNT = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, PFX_E0, PFX_F0, PFX_E0F0} state_e;

   state_e        state_q;
   logic [TW-1:0] tmo_q;
   logic [7:0]    status_q;
   logic          ovf_q;
   logic          irq_q;
   logic [AW:0]   wr_q, rd_q, wr_d, rd_d;
   logic [AW:0]   count;
   logic [9:0]    mem [DEPTH];
   logic [9:0]    head;
   logic          is_status, is_e0, is_f0;
   logic          dec_push, dec_ext, dec_rel, push_req;
   logic          empty, full, pop_eff, accept, ovf_set;

   // Classify the incoming byte; status codes override any prefix handling.
   always_comb begin
      is_status = 1'b0;
      case (bus.RX_DATA)
         8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'hFD, 8'h00, 8'hFF: is_status = 1'b1;
         default: is_status = 1'b0;
      endcase
      is_e0    = (bus.RX_DATA == 8'hE0);
      is_f0    = (bus.RX_DATA == 8'hF0);
      dec_ext  = (state_q == PFX_E0) || (state_q == PFX_E0F0);
      dec_rel  = (state_q == PFX_F0) || (state_q == PFX_E0F0);
      dec_push = bus.RX_STB && !is_status && !is_e0 && !is_f0;
   end

`ifdef SCAN_TYPEMATIC_FILTER_EN
   logic       held_valid_q;
   logic       held_ext_q;
   logic [7:0] held_code_q;
   logic       held_match;

   // Suppress a make that repeats the key currently held down.
   always_comb begin
      held_match = held_valid_q && (held_ext_q == dec_ext) && (held_code_q == bus.RX_DATA);
      push_req   = dec_push && !(!dec_rel && held_match);
   end

   // Track the last pushed make; its matching release frees it.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         held_valid_q <= 1'b0;
         held_ext_q   <= 1'b0;
         held_code_q  <= '0;
      end else if (push_req && !dec_rel) begin
         held_valid_q <= 1'b1;
         held_ext_q   <= dec_ext;
         held_code_q  <= bus.RX_DATA;
      end else if (push_req && dec_rel && held_match) begin
         held_valid_q <= 1'b0;
      end
   end
`else
   // Every decoded event goes to the FIFO.
   always_comb begin
      push_req = dec_push;
   end
`endif

   // Prefix decoder with timeout and device-status capture.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         tmo_q    <= '0;
         status_q <= '0;
      end else if (bus.RX_STB) begin
         tmo_q <= '0;
         if (is_status) begin
            status_q <= bus.RX_DATA;
            state_q  <= IDLE;
         end else if (is_e0) begin
            state_q <= PFX_E0;
         end else if (is_f0) begin
            if (state_q == PFX_E0 || state_q == PFX_E0F0) state_q <= PFX_E0F0;
            else                                          state_q <= PFX_F0;
         end else begin
            state_q <= IDLE;
         end
      end else if (state_q != IDLE) begin
         if (tmo_q == TMAX) begin
            state_q <= IDLE;
            tmo_q   <= '0;
         end else begin
            tmo_q <= tmo_q + 1'b1;
         end
      end
   end

   // FIFO bookkeeping: a POP on a full FIFO frees the slot for a same-cycle push.
   always_comb begin
      count   = wr_q - rd_q;
      empty   = (count == '0);
      full    = (count == FULLCNT);
      pop_eff = bus.POP && !empty;
      accept  = push_req && (!full || pop_eff);
      ovf_set = push_req && full && !pop_eff;
      wr_d    = wr_q + {{AW{1'b0}}, accept};
      rd_d    = rd_q + {{AW{1'b0}}, pop_eff};
      head    = mem[rd_q[AW-1:0]];
   end

   // Entry storage, written at the strobe edge; contents need no reset.
   always_ff @(posedge CLOCK) begin
      if (accept) mem[wr_q[AW-1:0]] <= {dec_ext, dec_rel, bus.RX_DATA};
   end

   // Pointers, sticky overflow (set beats clear) and arrival toggle.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         irq_q <= irq_q ^ accept;
         if (ovf_set)          ovf_q <= 1'b1;
         else if (bus.CLR_OVF) ovf_q <= 1'b0;
      end
   end

   assign bus.O_CODE   = empty ? '0 : head[7:0];
   assign bus.O_REL    = !empty && head[8];
   assign bus.O_EXT    = !empty && head[9];
   assign bus.O_EMPTY  = empty;
   assign bus.O_COUNT  = count;
   assign bus.O_OVF    = ovf_q;
   assign bus.O_STATUS = status_q;
   assign bus.O_IRQ    = irq_q;
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Testbench for ps2_scan_fifo (DEPTH=16, short TIMEOUT).
module tb_ps2_scan_fifo;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned TIMEOUT = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ps2_scan_fifo_if #(.DEPTH(DEPTH)) bus ();
   ps2_scan_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .CLOCK   (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [7:0] data;
      logic       push;
      logic       ext;
      logic       rel;
      logic [7:0] status;
   } vec_t;

   vec_t        tbl[22];
   logic [9:0]  sb[$];
   logic        irq_exp;
   logic        rep_push;
   int unsigned n_pass;
   int unsigned n_total;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cycle(input logic stb, input logic [7:0] d, input logic pop, input logic clr);
      @(negedge clk);
      bus.RX_STB  = stb;
      bus.RX_DATA = d;
      bus.POP     = pop;
      bus.CLR_OVF = clr;
      @(posedge clk);
      #1;
      bus.RX_STB  = 1'b0;
      bus.POP     = 1'b0;
      bus.CLR_OVF = 1'b0;
   endtask

   task automatic send_exp(input logic [7:0] b, input logic push, input logic ext, input logic rel);
      cycle(1'b1, b, 1'b0, 1'b0);
      if (push) begin
         sb.push_back({ext, rel, b});
         irq_exp = ~irq_exp;
      end
      check("irq", 32'(bus.O_IRQ), 32'(irq_exp));
      check("count", 32'(bus.O_COUNT), sb.size());
   endtask

   task automatic check_head(input string name);
      check(name, 32'({bus.O_EXT, bus.O_REL, bus.O_CODE}), 32'(sb[0]));
   endtask

   task automatic drain();
      while (sb.size() != 0) begin
         check_head("head");
         check("nonempty", 32'(bus.O_EMPTY), 32'd0);
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         void'(sb.pop_front());
      end
      check("empty", 32'(bus.O_EMPTY), 32'd1);
      check("count0", 32'(bus.O_COUNT), 32'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_code", 32'(bus.O_CODE), 32'd0);
      check("rst_rel", 32'(bus.O_REL), 32'd0);
      check("rst_ext", 32'(bus.O_EXT), 32'd0);
      check("rst_empty", 32'(bus.O_EMPTY), 32'd1);
      check("rst_count", 32'(bus.O_COUNT), 32'd0);
      check("rst_ovf", 32'(bus.O_OVF), 32'd0);
      check("rst_status", 32'(bus.O_STATUS), 32'd0);
      check("rst_irq", 32'(bus.O_IRQ), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      bus.RX_STB = 1'b0; bus.RX_DATA = 8'h00; bus.POP = 1'b0; bus.CLR_OVF = 1'b0;
      irq_exp = 1'b0; n_pass = 0; n_total = 0;

      tbl[0]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 8'h00};
      tbl[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4]  = '{8'h75, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[7]  = '{8'h75, 1'b1, 1'b1, 1'b1, 8'h00};
      tbl[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[9]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[10] = '{8'h2B, 1'b1, 1'b0, 1'b1, 8'h00};
      tbl[11] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[12] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[13] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[14] = '{8'h74, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[15] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[16] = '{8'hAA, 1'b0, 1'b0, 1'b0, 8'hAA};
      tbl[17] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'hAA};
      tbl[18] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'hAA};
      tbl[19] = '{8'hFA, 1'b0, 1'b0, 1'b0, 8'hFA};
      tbl[20] = '{8'hFC, 1'b0, 1'b0, 1'b0, 8'hFC};
      tbl[21] = '{8'h29, 1'b1, 1'b0, 1'b0, 8'hFC};

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs();

      // Decode table
      for (int i = 0; i < 22; i++) begin
         send_exp(tbl[i].data, tbl[i].push, tbl[i].ext, tbl[i].rel);
         check("status", 32'(bus.O_STATUS), 32'(tbl[i].status));
      end
      drain();

      // Fill to DEPTH, then one more make overflows
      for (int i = 0; i < 16; i++) send_exp(8'(16 + i), 1'b1, 1'b0, 1'b0);
      check("ovf_at_full", 32'(bus.O_OVF), 32'd0);
      send_exp(8'h20, 1'b0, 1'b0, 1'b0);
      check("ovf_set", 32'(bus.O_OVF), 32'd1);
      check_head("head_after_ovf");
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr", 32'(bus.O_OVF), 32'd0);
      cycle(1'b1, 8'h21, 1'b0, 1'b1);
      check("ovf_set_wins", 32'(bus.O_OVF), 32'd1);
      check("irq_no_toggle", 32'(bus.O_IRQ), 32'(irq_exp));
      check("count_full", 32'(bus.O_COUNT), 32'd16);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr2", 32'(bus.O_OVF), 32'd0);

      // Full: POP and push in the same cycle
      cycle(1'b1, 8'h33, 1'b1, 1'b0);
      void'(sb.pop_front());
      sb.push_back({2'b00, 8'h33});
      irq_exp = ~irq_exp;
      check("full_pp_count", 32'(bus.O_COUNT), 32'd16);
      check("full_pp_ovf", 32'(bus.O_OVF), 32'd0);
      check("full_pp_irq", 32'(bus.O_IRQ), 32'(irq_exp));
      check_head("full_pp_head");
      drain();

      // POP on empty, then POP+push on empty
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("pop_empty_count", 32'(bus.O_COUNT), 32'd0);
      check("pop_empty_flag", 32'(bus.O_EMPTY), 32'd1);
      cycle(1'b1, 8'h44, 1'b1, 1'b0);
      sb.push_back({2'b00, 8'h44});
      irq_exp = ~irq_exp;
      check("empty_pp_count", 32'(bus.O_COUNT), 32'd1);
      check("empty_pp_irq", 32'(bus.O_IRQ), 32'(irq_exp));
      drain();

      // Typematic repeats
`ifdef SCAN_TYPEMATIC_FILTER_EN
      rep_push = 1'b0;
`else
      rep_push = 1'b1;
`endif
      send_exp(8'h1C, 1'b1, 1'b0, 1'b0);
      send_exp(8'h1C, rep_push, 1'b0, 1'b0);
      send_exp(8'h1C, rep_push, 1'b0, 1'b0);
      send_exp(8'hF0, 1'b0, 1'b0, 1'b0);
      send_exp(8'h1C, 1'b1, 1'b0, 1'b1);
`ifdef SCAN_TYPEMATIC_FILTER_EN
      check("typematic_count", 32'(bus.O_COUNT), 32'd2);
`else
      check("typematic_count", 32'(bus.O_COUNT), 32'd4);
`endif
      drain();

      // Prefix timeout: just inside keeps the prefix, just past drops it
      send_exp(8'hE0, 1'b0, 1'b0, 1'b0);
      repeat (TIMEOUT - 2) @(posedge clk);
      #1;
      send_exp(8'h75, 1'b1, 1'b1, 1'b0);
      send_exp(8'hE0, 1'b0, 1'b0, 1'b0);
      repeat (TIMEOUT) @(posedge clk);
      #1;
      send_exp(8'h1C, 1'b1, 1'b0, 1'b0);
      drain();

      // Status byte mid-prefix
      send_exp(8'hF0, 1'b0, 1'b0, 1'b0);
      send_exp(8'hAA, 1'b0, 1'b0, 1'b0);
      check("status_mid_pfx", 32'(bus.O_STATUS), 32'hAA);
      send_exp(8'h3A, 1'b1, 1'b0, 1'b0);
      drain();

      // Asynchronous reset mid-FIFO and mid-prefix
      send_exp(8'h2B, 1'b1, 1'b0, 1'b0);
      send_exp(8'hE0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs();
      sb.delete();
      irq_exp = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      send_exp(8'h1C, 1'b1, 1'b0, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
